spio_hss_multiplexer_handshake: RTL

- Sits between the spinnlink high-speed-link ports (hsl_*/ihsl_*) and the serial transceiver.
- Runs link bring-up: exchanges handshake words with the remote end and declares the link up after enough matching handshakes are received.
- Once up, passes frames through, periodically injects keep-alive handshakes, and strips received handshakes before they reach the frame disassembler.
- Declares the link down on handshake loss.

---
 rtl/spio_hss_multiplexer_handshake.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/spio_hss_multiplexer_handshake.sv
// rtl/spio_hss_multiplexer_handshake.sv - HSS link bring-up, keep-alive handshake injection and rx handshake stripping
module spio_hss_multiplexer_handshake #(
  parameter int         HS_PERIOD    = 1024,
  parameter int         HS_REQ       = 16,
  parameter int         LOSS_TIMEOUT = 4096,
  parameter logic [7:0] VERSION      = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] spl_hsl_data,
  input  logic [3:0]  spl_hsl_kchr,
  input  logic        spl_hsl_vld,
  output logic        spl_hsl_rdy,
  output logic [31:0] tx_data,
  output logic [3:0]  tx_kchr,
  output logic        tx_vld,
  input  logic        tx_rdy,
  input  logic [31:0] rx_data,
  input  logic [3:0]  rx_kchr,
  input  logic        rx_vld,
  output logic [31:0] spl_ihsl_data,
  output logic [3:0]  spl_ihsl_kchr,
  output logic        spl_ihsl_vld,
  output logic        link_up,
  output logic        reg_hand,
  output logic        reg_vmis
);

  localparam int PW = (HS_PERIOD > 1) ? $clog2(HS_PERIOD) : 1;
  localparam int CW = $clog2(HS_REQ + 1);
  localparam int LW = (LOSS_TIMEOUT > 1) ? $clog2(LOSS_TIMEOUT) : 1;

  localparam logic [31:0]   HS_WORD       = {8'h5A, VERSION, 8'h00, 8'hBC};
  localparam logic [PW-1:0] PERIOD_RELOAD = PW'(HS_PERIOD - 1);
  localparam logic [CW-1:0] REQ_FULL      = CW'(HS_REQ);
  localparam logic [CW-1:0] REQ_LAST      = CW'(HS_REQ - 1);
  localparam logic [LW-1:0] LOSS_LAST     = LW'(LOSS_TIMEOUT - 1);

  typedef enum logic {ST_HANDSHAKE, ST_UP} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   period_cnt;
  logic [CW-1:0]   rx_cnt, rx_cnt_nxt;
  logic [LW-1:0]   loss_cnt, loss_cnt_nxt;
  logic            inject_pend;

  logic rx_good, rx_mis, load_ok, hs_load, spl_load, period_exp;

  assign rx_good    = (rx_kchr == 4'b0001) && (rx_data == HS_WORD);
  assign rx_mis     = (rx_kchr == 4'b0001) && (rx_data[31:24] == 8'h5A) &&
                      (rx_data[7:0] == 8'hBC) && (rx_data[23:16] != VERSION);
  assign load_ok    = !tx_vld || tx_rdy;
  assign period_exp = (period_cnt == '0);
  assign hs_load    = load_ok && inject_pend;
  assign spl_hsl_rdy = load_ok && !inject_pend && (state == ST_UP);
  assign spl_load   = spl_hsl_vld && spl_hsl_rdy;
  assign link_up    = (state == ST_UP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_HANDSHAKE;
      rx_cnt   <= '0;
      loss_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      loss_cnt <= loss_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rx_cnt_nxt   = rx_cnt;
    loss_cnt_nxt = loss_cnt;
    case (state)
      ST_HANDSHAKE: begin
        if (rx_vld) begin
          if (rx_good) begin
            if (rx_cnt >= REQ_LAST) begin
              rx_cnt_nxt   = REQ_FULL;
              state_nxt    = ST_UP;
              loss_cnt_nxt = '0;
            end else begin
              rx_cnt_nxt = rx_cnt + 1'b1;
            end
          end else begin
            rx_cnt_nxt = '0;
          end
        end
      end
      ST_UP: begin
        // only a good handshake counts as keep-alive; a mismatch does not drop the link
        if (rx_vld && rx_good) begin
          loss_cnt_nxt = '0;
        end else if (loss_cnt == LOSS_LAST) begin
          state_nxt    = ST_HANDSHAKE;
          rx_cnt_nxt   = '0;
          loss_cnt_nxt = '0;
        end else begin
          loss_cnt_nxt = loss_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_HANDSHAKE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      period_cnt    <= PERIOD_RELOAD;
      inject_pend   <= 1'b1;
      tx_data       <= '0;
      tx_kchr       <= '0;
      tx_vld        <= 1'b0;
      spl_ihsl_data <= '0;
      spl_ihsl_kchr <= '0;
      spl_ihsl_vld  <= 1'b0;
      reg_hand      <= 1'b0;
      reg_vmis      <= 1'b0;
    end else begin
      period_cnt <= period_exp ? PERIOD_RELOAD : period_cnt - 1'b1;
      // a period expiring in the same cycle as an injection re-arms the next one
      if (period_exp)   inject_pend <= 1'b1;
      else if (hs_load) inject_pend <= 1'b0;

      if (hs_load) begin
        tx_data <= HS_WORD;
        tx_kchr <= 4'b0001;
        tx_vld  <= 1'b1;
      end else if (spl_load) begin
        tx_data <= spl_hsl_data;
        tx_kchr <= spl_hsl_kchr;
        tx_vld  <= 1'b1;
      end else if (load_ok) begin
        tx_vld  <= 1'b0;
      end

      spl_ihsl_data <= rx_data;
      spl_ihsl_kchr <= rx_kchr;
      spl_ihsl_vld  <= rx_vld && (state == ST_UP) && !rx_good && !rx_mis;

      reg_hand <= rx_vld && rx_good;
      if (rx_vld && rx_mis)       reg_vmis <= 1'b1;
      else if (rx_vld && rx_good) reg_vmis <= 1'b0;
    end
  end

endmodule
